// File: rtl/iot_event_arbiter.sv
// iot_event_arbiter: synchronises per-device status lines, turns level
// changes into pending on/off events, and emits them one per clock through a
// round-robin arbiter. Opposite edges that arrive before service cancel out.
module iot_event_arbiter #(
    parameter int N_DEV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_status,
    output logic             change,
    output logic             on_off,
    output logic [N_DEV-1:0] dev_active,
    output logic             busy
);

    localparam int PTR_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    logic [N_DEV-1:0] s1_q, s1_d;
    logic [N_DEV-1:0] s2_q, s2_d;
    logic [N_DEV-1:0] hist_q, hist_d;
    logic [N_DEV-1:0] pend_q, pend_d;
    logic [N_DEV-1:0] pdir_q, pdir_d;
    logic [N_DEV-1:0] dev_active_q, dev_active_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             change_q, change_d;
    logic             on_off_q, on_off_d;
    logic             busy_q, busy_d;

    logic [N_DEV-1:0] edge_vec;
    logic             grant_valid;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] cand;

    // Adds an offset to the round-robin pointer, wrapping at N_DEV
    // (N_DEV need not be a power of two).
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= N_DEV) begin
            sum = sum - N_DEV;
        end
        return PTR_W'(sum);
    endfunction

    // Synchroniser chain plus history stage used for edge detection.
    always_comb begin
        s1_d   = dev_status;
        s2_d   = s1_q;
        hist_d = s2_q;
    end

    assign edge_vec = s2_q ^ hist_q;

    // Round-robin search: first pending device at or after the pointer.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_DEV; k++) begin
            cand = wrap_idx(ptr_q, k);
            if (!grant_valid && pend_q[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Grant servicing, pending-event bookkeeping and cancellation.
    always_comb begin
        pend_d       = pend_q;
        pdir_d       = pdir_q;
        dev_active_d = dev_active_q;
        change_d     = 1'b0;
        on_off_d     = on_off_q;
        ptr_d        = ptr_q;

        if (grant_valid) begin
            change_d                = 1'b1;
            on_off_d                = pdir_q[grant_idx];
            dev_active_d[grant_idx] = pdir_q[grant_idx];
            pend_d[grant_idx]       = 1'b0;
            ptr_d = (grant_idx == PTR_W'(N_DEV - 1)) ? '0 : grant_idx + 1'b1;
        end

        // A new edge re-arms a free or just-granted device; otherwise an
        // opposite-direction edge cancels the pending event.
        for (int i = 0; i < N_DEV; i++) begin
            if (edge_vec[i]) begin
                if (!pend_q[i] || (grant_valid && grant_idx == PTR_W'(i))) begin
                    pend_d[i] = 1'b1;
                    pdir_d[i] = s2_q[i];
                end else if (pdir_q[i] != s2_q[i]) begin
                    pend_d[i] = 1'b0;
                end
            end
        end

        busy_d = |pend_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            hist_q       <= '0;
            pend_q       <= '0;
            pdir_q       <= '0;
            dev_active_q <= '0;
            ptr_q        <= '0;
            change_q     <= 1'b0;
            on_off_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            hist_q       <= hist_d;
            pend_q       <= pend_d;
            pdir_q       <= pdir_d;
            dev_active_q <= dev_active_d;
            ptr_q        <= ptr_d;
            change_q     <= change_d;
            on_off_q     <= on_off_d;
            busy_q       <= busy_d;
        end
    end

    assign change     = change_q;
    assign on_off     = on_off_q;
    assign dev_active = dev_active_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Testbench for iot_event_arbiter: vector table plus hand-written corner
// sequences, with a queue scoreboard of expected events in grant order.
module tb_iot_event_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] dev_status = '0;
    logic         change;
    logic         on_off;
    logic [N-1:0] dev_active;
    logic         busy;

    typedef struct {
        int  dev;
        logic dir;
    } ev_t;

    typedef struct {
        logic [7:0] status;
        logic [7:0] exp_active;
        int         exp_pulses;
        int         exp_first;
    } vec_t;

    ev_t        sb_q[$];
    vec_t       vecs[6];
    int         errors = 0;
    int         checks = 0;
    int         pulse_cnt = 0;
    int         first_dev = -1;
    int         mptr = 0;
    logic [7:0] mcur = '0;
    logic [7:0] act_prev = '0;
    logic [7:0] cnt8 = '0;
    bit         sb_en = 1'b1;

    iot_event_arbiter #(.N_DEV(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .dev_status (dev_status),
        .change     (change),
        .on_off     (on_off),
        .dev_active (dev_active),
        .busy       (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Global watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: with the arbiter idle and all edges arriving together, events
    // come out in ascending order starting at the round-robin pointer.
    task automatic model_push(input logic [7:0] val);
        logic [7:0] diff;
        int idx;
        int last;
        ev_t e;
        diff = mcur ^ val;
        last = -1;
        for (int k = 0; k < N; k++) begin
            idx = (mptr + k) % N;
            if (diff[idx]) begin
                e.dev = idx;
                e.dir = val[idx];
                sb_q.push_back(e);
                last = idx;
            end
        end
        if (last >= 0) mptr = (last + 1) % N;
        mcur = val;
    endtask

    task automatic applyStimulus(input logic [7:0] val);
        dev_status = val;
        model_push(val);
    endtask

    task automatic start_count();
        pulse_cnt = 0;
        first_dev = -1;
    endtask

    task automatic sample_cycle();
        ev_t e;
        logic [7:0] diff;
        @(negedge clk);
        if (sb_en && change === 1'b1) begin
            pulse_cnt++;
            diff = dev_active ^ act_prev;
            if (first_dev < 0) begin
                for (int b = N - 1; b >= 0; b--) if (diff[b]) first_dev = b;
            end
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("pulse_dir", 32'(on_off), 32'(e.dir));
                checkOutput("pulse_dev", 32'(diff), 32'd1 << e.dev);
            end
        end
        act_prev = dev_active;
    endtask

    task automatic run_until_idle(input int budget);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            sample_cycle();
            n++;
            if (n >= 4 && sb_q.size() == 0 && busy === 1'b0 && change === 1'b0)
                done = 1'b1;
        end
        if (!done) checkOutput("idle_timeout", 32'd0, 32'd1);
        repeat (3) sample_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        mptr = 0;
        mcur = '0;
        act_prev = '0;
        model_push(dev_status);
    endtask

    initial begin
        int n;

        vecs[0] = '{8'hFF, 8'hFF, 7, 3};
        vecs[1] = '{8'hDF, 8'hDF, 1, 5};
        vecs[2] = '{8'h9B, 8'h9B, 2, 6};
        vecs[3] = '{8'h00, 8'h00, 5, 3};
        vecs[4] = '{8'hA5, 8'hA5, 4, 2};
        vecs[5] = '{8'h5A, 8'h5A, 8, 1};

        // Reset values
        do_reset();
        checkOutput("reset_change", 32'(change), 32'd0);
        checkOutput("reset_on_off", 32'(on_off), 32'd0);
        checkOutput("reset_active", 32'(dev_active), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);

        // Single on event: exact latency and one-cycle busy
        start_count();
        applyStimulus(8'h04);
        for (int c = 1; c <= 3; c++) begin
            sample_cycle();
            checkOutput("single_latency_change", 32'(change), 32'd0);
        end
        checkOutput("single_busy_pre", 32'(busy), 32'd1);
        sample_cycle();
        checkOutput("single_change", 32'(change), 32'd1);
        checkOutput("single_on_off", 32'(on_off), 32'd1);
        checkOutput("single_active", 32'(dev_active), 32'h04);
        checkOutput("single_busy_post", 32'(busy), 32'd0);
        sample_cycle();
        checkOutput("single_one_cycle", 32'(change), 32'd0);
        run_until_idle(10);

        // Vector table, including round-robin fairness (row 2: 6 before 2)
        for (int v = 0; v < 6; v++) begin
            start_count();
            applyStimulus(vecs[v].status);
            run_until_idle(40);
            checkOutput("vec_pulses", 32'(pulse_cnt), 32'(vecs[v].exp_pulses));
            checkOutput("vec_first_dev", 32'(first_dev), 32'(vecs[v].exp_first));
            checkOutput("vec_active", 32'(dev_active), 32'(vecs[v].exp_active));
            checkOutput("vec_busy", 32'(busy), 32'd0);
        end

        // Simultaneous on events from reset: order 0..7, busy drops on 8th
        dev_status = '0;
        do_reset();
        start_count();
        applyStimulus(8'hFF);
        n = 0;
        while (pulse_cnt < 8 && n < 30) begin
            sample_cycle();
            n++;
            if (change === 1'b1) begin
                if (pulse_cnt < 8) checkOutput("burst_busy", 32'(busy), 32'd1);
                else checkOutput("burst_busy_last", 32'(busy), 32'd0);
            end
        end
        checkOutput("burst_pulses", 32'(pulse_cnt), 32'd8);
        run_until_idle(10);
        checkOutput("burst_first_dev", 32'(first_dev), 32'd0);
        checkOutput("burst_active", 32'(dev_active), 32'hFF);

        // Cancellation under contention: device 7 reverses while pending
        dev_status = '0;
        do_reset();
        start_count();
        applyStimulus(8'hFF);
        sample_cycle();
        sample_cycle();
        dev_status = 8'h7F;
        mcur = 8'h7F;
        void'(sb_q.pop_back());
        run_until_idle(40);
        checkOutput("cancel_pulses", 32'(pulse_cnt), 32'd7);
        checkOutput("cancel_active", 32'(dev_active), 32'h7F);

        // Reset mid-burst, then a fresh burst from device 0
        dev_status = '0;
        do_reset();
        start_count();
        applyStimulus(8'hFF);
        n = 0;
        while (pulse_cnt < 3 && n < 20) begin
            sample_cycle();
            n++;
        end
        checkOutput("midrst_pre_pulses", 32'(pulse_cnt), 32'd3);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_change", 32'(change), 32'd0);
        checkOutput("midrst_on_off", 32'(on_off), 32'd0);
        checkOutput("midrst_active", 32'(dev_active), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        sb_q.delete();
        mptr = 0;
        mcur = '0;
        act_prev = '0;
        model_push(8'hFF);
        start_count();
        run_until_idle(40);
        checkOutput("midrst_post_pulses", 32'(pulse_cnt), 32'd8);
        checkOutput("midrst_first_dev", 32'(first_dev), 32'd0);
        checkOutput("midrst_post_active", 32'(dev_active), 32'hFF);

        // Random toggling with an up/down counter fed by the event stream
        dev_status = '0;
        do_reset();
        sb_en = 1'b0;
        cnt8 = '0;
        for (int c = 0; c < 10030; c++) begin
            @(negedge clk);
            if (change === 1'b1) cnt8 = on_off ? cnt8 + 8'd1 : cnt8 - 8'd1;
            checkOutput("count_vs_active", 32'(cnt8), 32'($countones(dev_active)));
            if (c < 10000) dev_status = dev_status ^ 8'($urandom & $urandom & $urandom);
        end
        checkOutput("random_busy_idle", 32'(busy), 32'd0);
        checkOutput("random_count_vs_status", 32'(cnt8), 32'($countones(dev_status)));
        checkOutput("random_active_vs_status", 32'(dev_active), 32'(dev_status));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
